memory_bin_reader: RTL

//  Read-side sequencer for one binned, double-paged Memory instance (8 bins x 16 entries x 2 pages).
//  On start it snapshots the 8 per-bin entry counts for the selected page.
//  It then drives the Memory read port (addrb/enb/regceb) to stream every stored entry, bin by bin.

---
 rtl/memory_bin_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/memory_bin_reader.sv
// Read sequencer for a binned, double-paged Memory (8 bins x 16 x 2 pages).
// Snapshots per-bin counts on start, streams every entry with aligned tags.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   start, bx[2:0]       begin readout (IDLE only), page = bx[0]
//   nent_flat[63:0]      per-bin/page entry counts, nibble at 8b+4p
//   addrb, enb, regceb   Memory read port
//   busy                 high from accepted start through done
//   data_valid/bin/last  tags aligned with doutb
//   done                 one-cycle completion pulse
module memory_bin_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int RAM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            bx,
  input  logic [63:0]           nent_flat,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  enb,
  output logic                  regceb,
  output logic                  busy,
  output logic                  data_valid,
  output logic [2:0]            data_bin,
  output logic                  data_last,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic       r_page;
  logic [3:0] r_cnt [8];
  logic [2:0] r_bin;
  logic [3:0] r_entry;
  logic       r_busy;
  logic       r_empty;
  logic       r_ewait;

  logic [RAM_LATENCY-1:0] r_pv;
  logic [RAM_LATENCY-1:0] r_pl;
  logic [2:0]             r_pb [RAM_LATENCY];

  logic [3:0] w_in_cnt [8];
  logic [7:0] w_in_mask;
  logic       w_in_any;
  logic [2:0] w_first;
  logic [7:0] w_mask;
  logic       w_more;
  logic [2:0] w_nxt;
  logic       w_wrap;
  logic       w_last;
  logic       w_done;
  logic       w_unused_bx;

  assign w_unused_bx = ^bx[2:1];

  // Counts for the page being requested, and the first nonempty bin.
  always_comb begin
    w_first = '0;
    for (int b = 0; b < 8; b++) begin
      w_in_cnt[b]  = nent_flat[8*b + 4*int'(bx[0]) +: 4];
      w_in_mask[b] = (w_in_cnt[b] != 4'd0);
    end
    for (int b = 7; b >= 0; b--) begin
      if (w_in_mask[b]) w_first = 3'(b);
    end
    w_in_any = |w_in_mask;
  end

  // Next nonempty bin above the current one, so empty bins cost no cycles.
  always_comb begin
    w_more = 1'b0;
    w_nxt  = r_bin;
    for (int b = 0; b < 8; b++) begin
      w_mask[b] = (r_cnt[b] != 4'd0);
    end
    for (int b = 7; b >= 0; b--) begin
      if (w_mask[b] && (3'(b) > r_bin)) begin
        w_more = 1'b1;
        w_nxt  = 3'(b);
      end
    end
  end

  assign w_wrap = (r_entry == r_cnt[r_bin] - 4'd1);
  assign w_last = (r_state == S_READ) && w_wrap && !w_more;

  // Empty readouts have no tag in the pipe; wait one DRAIN cycle instead.
  assign w_done = (r_state == S_DRAIN) &&
                  (r_empty ? r_ewait : r_pl[RAM_LATENCY-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = w_in_any ? S_READ : S_DRAIN;
      S_READ:  if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    enb  = (r_state == S_READ);
    done = w_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page  <= 1'b0;
      r_cnt   <= '{default: '0};
      r_bin   <= '0;
      r_entry <= '0;
      r_busy  <= 1'b0;
      r_empty <= 1'b0;
      r_ewait <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_page  <= bx[0];
            r_cnt   <= w_in_cnt;
            r_busy  <= 1'b1;
            r_bin   <= w_first;
            r_entry <= '0;
            r_empty <= ~w_in_any;
            r_ewait <= 1'b0;
          end
        end
        S_READ: begin
          // Address holds on the final read; enb drops with the state.
          if (w_wrap) begin
            if (w_more) begin
              r_bin   <= w_nxt;
              r_entry <= '0;
            end
          end else begin
            r_entry <= r_entry + 4'd1;
          end
        end
        S_DRAIN: begin
          if (r_empty) r_ewait <= 1'b1;
          if (w_done)  r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag pipe matching the Memory read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pl <= '0;
      r_pb <= '{default: '0};
    end else begin
      r_pv[0] <= (r_state == S_READ);
      r_pl[0] <= w_last;
      r_pb[0] <= r_bin;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  always_comb begin
    addrb      = '0;
    addrb[7:0] = {r_page, r_bin, r_entry};
  end

  assign regceb     = (RAM_LATENCY == 2);
  assign busy       = r_busy;
  assign data_valid = r_pv[RAM_LATENCY-1];
  assign data_last  = r_pl[RAM_LATENCY-1];
  assign data_bin   = r_pb[RAM_LATENCY-1];

endmodule
